// File: rtl/bus_bridge_pkg.sv
// Shared constants and types for the CPU-to-peripheral bus bridge: region bases,
// FSM state encoding, one-hot region type and the address decoder.
package ogege_bus_pkg;

  localparam logic [8:0]  PSRAM_HI = 9'h080;
  localparam logic [24:0] TEXT_HI  = 25'h00001FE;
  localparam logic [15:0] BRAM_HI  = 16'h0000;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  // Bit positions match the chip-select outputs: [0] PSRAM, [1] text, [2] BRAM.
  typedef enum logic [2:0] {
    REG_NONE  = 3'b000,
    REG_PSRAM = 3'b001,
    REG_TEXT  = 3'b010,
    REG_BRAM  = 3'b100
  } region_e;

  // Text sits inside the BRAM window, so it must be tested before BRAM.
  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr[31:23] == PSRAM_HI) return REG_PSRAM;
    if (addr[31:7] == TEXT_HI) return REG_TEXT;
    if (addr[31:16] == BRAM_HI) return REG_BRAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/bus_bridge_if.sv
// CPU-side bus of the bridge: level-held request with a four-phase ready handshake.
interface bus_bridge_if;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output stb, we, addr, wdata, input rdata, ready, err);
  modport slave  (input stb, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/bus_bridge_sync.sv
// Multi-flop synchronizer with asynchronous reset to a configurable value.
module bus_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_100mhz,
  input  logic rstn_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignment so each stage takes the previous stage's old value.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) chain <= {STAGES{RST_VAL}};
    else         chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_bridge.sv
// Bus bridge: synchronizes the CPU strobe, decodes a one-hot chip select, pulses the
// peripheral strobe and returns read data. Optional WAIT timeout under BUS_TIMEOUT_EN.
module bus_bridge
  import ogege_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clk_100mhz,
  input  logic         rstn_i,
  bus_bridge_if.slave  cpu,
  output logic         o_psram_cs,
  output logic         o_text_cs,
  output logic         o_bram_cs,
  output logic         o_per_stb,
  output logic         o_per_we,
  output logic [23:0]  o_per_addr,
  output logic [31:0]  o_per_wdata,
  input  logic [15:0]  i_psram_rdata,
  input  logic         i_psram_done,
  input  logic [7:0]   i_text_rdata,
  input  logic         i_text_done,
  input  logic [31:0]  i_bram_rdata,
  input  logic         i_bram_done
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] RESP  = ST_RESP;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("bus_bridge: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES in 1..65535");
  end

  logic        stb_sync;
  logic        stb_prev;
  logic        stb_rise;
  logic [1:0]  state;
  region_e     region;
  region_e     region_new;
  logic [2:0]  region_bits;
  logic        busy;
  logic        sel_done;
  logic [31:0] sel_rdata;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic        tmo_hit;

  // Reset high so a strobe already held through reset release never looks like an edge.
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb_sync (
    .clk_100mhz (clk_100mhz),
    .rstn_i     (rstn_i),
    .d          (cpu.stb),
    .q          (stb_sync)
  );

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      stb_prev <= 1'b1;
      stb_rise <= 1'b0;
    end else begin
      stb_prev <= stb_sync;
      stb_rise <= stb_sync & ~stb_prev;
    end
  end

  assign region_new  = decode_region(cpu.addr);
  assign region_bits = region;
  assign busy        = (state == ISSUE) || (state == WAIT);
  assign sel_done    = |(region_bits & {i_bram_done, i_text_done, i_psram_done});

  // NOTE: default assignment first so no path leaves sel_rdata unassigned (no latch).
  always_comb begin
    sel_rdata = '0;
    case (region)
      REG_PSRAM: sel_rdata = {16'h0000, i_psram_rdata};
      REG_TEXT:  sel_rdata = {24'h000000, i_text_rdata};
      REG_BRAM:  sel_rdata = i_bram_rdata;
      default:   sel_rdata = '0;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i)            tmo_cnt <= '0;
    else if (state != WAIT) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; done has priority in the FSM.
  assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      region      <= REG_NONE;
      o_per_we    <= 1'b0;
      o_per_addr  <= '0;
      o_per_wdata <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_rise) begin
            o_per_we    <= cpu.we;
            o_per_addr  <= cpu.addr[23:0];
            o_per_wdata <= cpu.wdata;
            region      <= region_new;
            if (region_new == REG_NONE) begin
              rdata_q <= '0;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              state   <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (sel_done) begin
            rdata_q <= o_per_we ? '0 : sel_rdata;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (tmo_hit) begin
            rdata_q <= ERR_DATA;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (!stb_sync) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            region  <= REG_NONE;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_per_stb  = (state == ISSUE);
  assign o_psram_cs = busy & region_bits[0];
  assign o_text_cs  = busy & region_bits[1];
  assign o_bram_cs  = busy & region_bits[2];

  assign cpu.rdata = rdata_q;
  assign cpu.ready = ready_q;
  assign cpu.err   = err_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed vector table, reset corner cases and
// randomized transactions against an address-range reference model.
module tb_bus_bridge;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic        clk_100mhz;
  logic        rstn_i;
  logic        o_psram_cs, o_text_cs, o_bram_cs, o_per_stb, o_per_we;
  logic [23:0] o_per_addr;
  logic [31:0] o_per_wdata;
  logic [15:0] i_psram_rdata;
  logic        i_psram_done;
  logic [7:0]  i_text_rdata;
  logic        i_text_done;
  logic [31:0] i_bram_rdata;
  logic        i_bram_done;

  int n_checks = 0;
  int n_pass   = 0;

  bus_bridge_if cpu_bus();

  bus_bridge #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk_100mhz    (clk_100mhz),
    .rstn_i        (rstn_i),
    .cpu           (cpu_bus),
    .o_psram_cs    (o_psram_cs),
    .o_text_cs     (o_text_cs),
    .o_bram_cs     (o_bram_cs),
    .o_per_stb     (o_per_stb),
    .o_per_we      (o_per_we),
    .o_per_addr    (o_per_addr),
    .o_per_wdata   (o_per_wdata),
    .i_psram_rdata (i_psram_rdata),
    .i_psram_done  (i_psram_done),
    .i_text_rdata  (i_text_rdata),
    .i_text_done   (i_text_done),
    .i_bram_rdata  (i_bram_rdata),
    .i_bram_done   (i_bram_done)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] prd;
    logic [7:0]  trd;
    logic [31:0] brd;
    int          lat;     // done cycles after o_per_stb; 0 = never
    bit          noise;   // spurious dones (other peripherals, and own during stb)
    logic [2:0]  exp_cs;  // {bram, text, psram}
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [15:0] prd, input logic [7:0] trd, input logic [31:0] brd,
                              input int lat, input bit noise, input logic [2:0] exp_cs,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.prd = prd; v.trd = trd; v.brd = brd;
    v.lat = lat; v.noise = noise; v.exp_cs = exp_cs; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference model: region by plain address ranges, data zero-extended by peripheral width.
  function automatic void model(input logic we, input logic [31:0] a, input logic [15:0] prd,
                                input logic [7:0] trd, input logic [31:0] brd,
                                output logic [2:0] cs, output logic [31:0] rd, output logic err);
    cs = 3'b000; rd = 32'h0; err = 1'b0;
    if (a >= 32'h4000_0000 && a <= 32'h407F_FFFF) begin
      cs = 3'b001; rd = 32'(prd);
    end else if (a >= 32'h0000_FF00 && a <= 32'h0000_FF7F) begin
      cs = 3'b010; rd = 32'(trd);
    end else if (a <= 32'h0000_FFFF) begin
      cs = 3'b100; rd = brd;
    end else begin
      err = 1'b1;
    end
    if (we) rd = 32'h0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({cpu_bus.ready, cpu_bus.err, o_psram_cs, o_text_cs, o_bram_cs,
                               o_per_stb, o_per_we}), 32'h0);
    check({tag, "_rdata"}, cpu_bus.rdata, 32'h0);
    check({tag, "_paddr"}, 32'(o_per_addr), 32'h0);
    check({tag, "_pwdata"}, o_per_wdata, 32'h0);
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [15:0] prd, input logic [7:0] trd,
                         input logic [31:0] brd, input int lat, input bit noise,
                         input logic [2:0] exp_cs, input logic [31:0] exp_rd, input logic exp_err);
    bit          mapped, tmo;
    int          stb_cyc, rdy_cyc, n_stb, cs_multi, exp_rdy, fall;
    logic [2:0]  cs_now, cs_seen, cs_at_rdy;
    logic [23:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;
    mapped  = (exp_cs != 3'b000);
    tmo     = mapped && (lat == 0);
    exp_rdy = mapped ? SYNC + 2 + (tmo ? TMO : lat) + 1 : SYNC + 2;
    i_psram_rdata = prd; i_text_rdata = trd; i_bram_rdata = brd;
    cpu_bus.we = we; cpu_bus.addr = addr; cpu_bus.wdata = wdata; cpu_bus.stb = 1'b1;
    stb_cyc = -1; rdy_cyc = -1; n_stb = 0; cs_multi = 0; cs_seen = 3'b000; cs_at_rdy = 3'b000;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    for (int c = 1; c <= 200 && rdy_cyc < 0; c++) begin
      @(posedge clk_100mhz); #1;
      i_psram_done = 1'b0; i_text_done = 1'b0; i_bram_done = 1'b0;
      cs_now = {o_bram_cs, o_text_cs, o_psram_cs};
      if ($countones(cs_now) > 1) cs_multi++;
      cs_seen |= cs_now;
      if (o_per_stb) begin
        n_stb++;
        if (stb_cyc < 0) begin
          stb_cyc = c; cap_addr = o_per_addr; cap_wdata = o_per_wdata; cap_we = o_per_we;
        end
      end
      if (cpu_bus.ready) begin
        rdy_cyc = c; cs_at_rdy = cs_now;
      end else if (stb_cyc >= 0) begin
        if ((lat > 0 && c == stb_cyc + lat) || (noise && c == stb_cyc))
          {i_bram_done, i_text_done, i_psram_done} = exp_cs;
        if (noise && lat > 0 && c <= stb_cyc + lat)
          {i_bram_done, i_text_done, i_psram_done} = {i_bram_done, i_text_done, i_psram_done} | ~exp_cs;
      end
    end
    check({tag, "_ready_cycle"}, 32'(rdy_cyc), 32'(exp_rdy));
    check({tag, "_rdata"}, cpu_bus.rdata, exp_rd);
    check({tag, "_err"}, 32'(cpu_bus.err), 32'(exp_err));
    check({tag, "_stb_count"}, 32'(n_stb), mapped ? 32'd1 : 32'd0);
    check({tag, "_cs_seen"}, 32'(cs_seen), 32'(exp_cs));
    check({tag, "_cs_onehot"}, 32'(cs_multi), 32'd0);
    check({tag, "_cs_at_ready"}, 32'(cs_at_rdy), 32'd0);
    if (mapped) begin
      check({tag, "_stb_cycle"}, 32'(stb_cyc), 32'(SYNC + 2));
      check({tag, "_per_addr"}, 32'(cap_addr), 32'(addr[23:0]));
      check({tag, "_per_wdata"}, cap_wdata, wdata);
      check({tag, "_per_we"}, 32'(cap_we), 32'(we));
    end
    cpu_bus.stb = 1'b0;
    if (rdy_cyc >= 0) begin
      fall = -1;
      for (int k = 1; k <= SYNC + 6 && fall < 0; k++) begin
        @(posedge clk_100mhz); #1;
        if (!cpu_bus.ready) fall = k;
      end
      check({tag, "_release"}, 32'(fall), 32'(SYNC + 1));
      check({tag, "_err_clear"}, 32'(cpu_bus.err), 32'd0);
    end
    repeat (3) begin @(posedge clk_100mhz); #1; end
  endtask

  initial begin
    bit seen;
    int activity;
    logic [31:0] a, wd, brd, erd;
    logic [15:0] prd;
    logic [7:0]  trd;
    logic [2:0]  ecs;
    logic        eerr, we;
    int          lat;

    rstn_i = 1'b0;
    cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
    i_psram_rdata = '0; i_psram_done = 1'b0; i_text_rdata = '0; i_text_done = 1'b0;
    i_bram_rdata = '0; i_bram_done = 1'b0;
    repeat (3) begin @(posedge clk_100mhz); #1; end
    check_idle_outputs("por");
    rstn_i = 1'b1;
    repeat (5) begin @(posedge clk_100mhz); #1; end

    //        we    addr          wdata         prd      trd    brd           lat noise cs      rd            err
    vecs.push_back(mk(1'b1, 32'h0000_FF05, 32'h0000_0041, 16'h0, 8'h00, 32'h0,         3, 0, 3'b010, 32'h0,         1'b0));
    vecs.push_back(mk(1'b0, 32'h4000_0010, 32'h0,         16'h1234, 8'h00, 32'h0,     10, 0, 3'b001, 32'h0000_1234, 1'b0));
    vecs.push_back(mk(1'b0, 32'h2000_0000, 32'h0,         16'h0, 8'h00, 32'h0,         0, 0, 3'b000, 32'h0,         1'b1));
    vecs.push_back(mk(1'b0, 32'h0000_1234, 32'h0,         16'h0, 8'h00, 32'hCAFE_BABE, 4, 1, 3'b100, 32'hCAFE_BABE, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_FF7F, 32'h0,         16'h0, 8'hA5, 32'h0,         1, 1, 3'b010, 32'h0000_00A5, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_FF80, 32'h0,         16'h0, 8'h00, 32'h1234_5678, 2, 0, 3'b100, 32'h1234_5678, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_FEFF, 32'h0,         16'h0, 8'h00, 32'h0BAD_F00D, 1, 0, 3'b100, 32'h0BAD_F00D, 1'b0));
    vecs.push_back(mk(1'b0, 32'h407F_FFFF, 32'h0,         16'hFFFF, 8'h00, 32'h0,      5, 1, 3'b001, 32'h0000_FFFF, 1'b0));
    vecs.push_back(mk(1'b0, 32'h4080_0000, 32'h0,         16'h0, 8'h00, 32'h0,         0, 0, 3'b000, 32'h0,         1'b1));
    vecs.push_back(mk(1'b0, 32'h0001_0000, 32'h0,         16'h0, 8'h00, 32'h0,         0, 0, 3'b000, 32'h0,         1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF, 16'h0, 8'h00, 32'h1111_1111, 3, 0, 3'b100, 32'h0,         1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_FF00, 32'h0,         16'h0, 8'h80, 32'h0,         6, 1, 3'b010, 32'h0000_0080, 1'b0));
`ifdef BUS_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 32'h4000_0020, 32'h0,         16'h0, 8'h00, 32'h0,         0, 0, 3'b001, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(1'b0, 32'h4000_0024, 32'h0,         16'h5555, 8'h00, 32'h0,     16, 0, 3'b001, 32'h0000_5555, 1'b0));
`endif

    for (int i = 0; i < vecs.size(); i++)
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].prd,
              vecs[i].trd, vecs[i].brd, vecs[i].lat, vecs[i].noise, vecs[i].exp_cs,
              vecs[i].exp_rd, vecs[i].exp_err);

    // Reset in the middle of a PSRAM read, with the strobe held through release.
    cpu_bus.we = 1'b0; cpu_bus.addr = 32'h4000_0040; cpu_bus.wdata = 32'h0;
    i_psram_rdata = 16'h7777; cpu_bus.stb = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 50 && !seen; c++) begin
      @(posedge clk_100mhz); #1;
      if (o_per_stb) seen = 1'b1;
    end
    check("rst_mid_stb_seen", 32'(seen), 32'd1);
    repeat (3) begin @(posedge clk_100mhz); #1; end
    check("rst_mid_in_wait", 32'(o_psram_cs), 32'd1);
    rstn_i = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) begin @(posedge clk_100mhz); #1; end
    rstn_i = 1'b1;
    @(posedge clk_100mhz); #1;
    i_psram_done = 1'b1;
    @(posedge clk_100mhz); #1;
    i_psram_done = 1'b0;
    activity = 0;
    repeat (15) begin
      @(posedge clk_100mhz); #1;
      if (cpu_bus.ready || o_per_stb || o_psram_cs || o_text_cs || o_bram_cs) activity++;
    end
    check("rst_stale_activity", 32'(activity), 32'd0);
    cpu_bus.stb = 1'b0;
    repeat (5) begin @(posedge clk_100mhz); #1; end
    check("rst_after_drop_ready", 32'(cpu_bus.ready), 32'd0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h4000_0000 | ($urandom & 32'h007F_FFFF);
        1:       a = 32'h0000_FF00 + 32'($urandom_range(0, 127));
        2:       a = 32'($urandom_range(0, 32'hFFFF));
        default: a = $urandom;
      endcase
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      prd = 16'($urandom);
      trd = 8'($urandom);
      brd = $urandom;
      lat = $urandom_range(1, 12);
      model(we, a, prd, trd, brd, ecs, erd, eerr);
      run_txn($sformatf("rnd%0d", i), we, a, wd, prd, trd, brd, lat, 1'($urandom_range(0, 1)),
              ecs, erd, eerr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
